// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes one instruction at a time, drives the ALU operands and
// writes the captured ALU result back into a small register file (r0 hard-wired to zero).

package simple_processor_pkg;

    parameter int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        FuncAdd     = 2'd0,
        FuncAddi    = 2'd1,
        FuncSub     = 2'd2,
        FuncInvalid = 2'd3
    } func_t;

endpackage

module alu_issue_ctrl #(
    parameter int unsigned DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned NUM_REGS    = 8
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    input  logic [INSTR_WIDTH-1:0]      instr_i,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    output simple_processor_pkg::func_t func_o,
    output logic [DATA_WIDTH-1:0]       rs1_data_o,
    output logic [DATA_WIDTH-1:0]       rs2_data_o,
    output logic [5:0]                  imm_o,
    input  logic [DATA_WIDTH-1:0]       result_i,
    output logic                        wb_valid_o,
    output logic [2:0]                  wb_addr_o,
    output logic [DATA_WIDTH-1:0]       wb_data_o,
    output logic                        illegal_o,
    input  logic [2:0]                  dbg_addr_i,
    output logic [DATA_WIDTH-1:0]       dbg_data_o
);

    import simple_processor_pkg::func_t;
    import simple_processor_pkg::FuncAdd;
    import simple_processor_pkg::FuncAddi;
    import simple_processor_pkg::FuncSub;
    import simple_processor_pkg::FuncInvalid;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StWb   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    func_t                 func_q, func_d;
    logic [2:0]            rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [5:0]            imm_q, imm_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [3:0] opcode;
    logic [2:0] dec_rd, dec_rs1, dec_rs2;

    assign opcode  = instr_i[15:12];
    assign dec_rd  = instr_i[11:9];
    assign dec_rs1 = instr_i[8:6];
    assign dec_rs2 = instr_i[5:3];

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        func_d     = func_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        imm_d      = imm_q;
        wb_valid_d = 1'b0;
        illegal_d  = 1'b0;
        wb_data_d  = wb_data_q;
        regs_d     = regs_q;

        unique case (state_q)
            StIdle: begin
                // Ready rises on the first edge after reset release, then tracks the FSM.
                ready_d = 1'b1;
                if (instr_valid_i && ready_q) begin
                    state_d = StExec;
                    ready_d = 1'b0;
                    unique case (opcode)
                        4'd0, 4'd2: begin
                            func_d = (opcode == 4'd0) ? FuncAdd : FuncSub;
                            rd_d   = dec_rd;
                            rs1_d  = regs_q[dec_rs1];
                            rs2_d  = regs_q[dec_rs2];
                            imm_d  = '0;
                        end
                        4'd1: begin
                            func_d = FuncAddi;
                            rd_d   = dec_rd;
                            rs1_d  = regs_q[dec_rs1];
                            rs2_d  = '0;
                            imm_d  = instr_i[5:0];
                        end
                        default: begin
                            func_d = FuncInvalid;
                            rd_d   = '0;
                            rs1_d  = '0;
                            rs2_d  = '0;
                            imm_d  = '0;
                        end
                    endcase
                end
            end
            StExec: begin
                state_d = StWb;
                if (func_q != FuncInvalid) begin
                    wb_data_d  = result_i;
                    wb_valid_d = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            StWb: begin
                state_d = StIdle;
                ready_d = 1'b1;
                if (wb_valid_q && (rd_q != 3'd0)) begin
                    regs_d[rd_q] = wb_data_q;
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            func_q     <= FuncInvalid;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            wb_data_q  <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            func_q     <= func_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            imm_q      <= imm_d;
            wb_valid_q <= wb_valid_d;
            illegal_q  <= illegal_d;
            wb_data_q  <= wb_data_d;
            regs_q     <= regs_d;
        end
    end

    assign instr_ready_o = ready_q;
    assign func_o        = func_q;
    assign rs1_data_o    = rs1_q;
    assign rs2_data_o    = rs2_q;
    assign imm_o         = imm_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_addr_o     = rd_q;
    assign wb_data_o     = wb_data_q;
    assign illegal_o     = illegal_q;
    assign dbg_data_o    = (dbg_addr_i == 3'd0) ? '0 : regs_q[dbg_addr_i];

    a_wb_excl: assert property (@(posedge clk_i) disable iff (!arst_ni)
        !(wb_valid_o && illegal_o));
    a_wb_not_ready: assert property (@(posedge clk_i) disable iff (!arst_ni)
        (wb_valid_o || illegal_o) |-> !instr_ready_o);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized traffic
// compared against an architectural register-file model.

module tb_alu_issue_ctrl;

    import simple_processor_pkg::*;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b1;
    logic [15:0] instr_i = '0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    func_t       func_o;
    logic [31:0] rs1_data_o, rs2_data_o;
    logic [5:0]  imm_o;
    logic [31:0] result_i;
    logic        wb_valid_o;
    logic [2:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        illegal_o;
    logic [2:0]  dbg_addr_i = '0;
    logic [31:0] dbg_data_o;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] mregs [8];

    typedef struct {
        bit          timeout;
        int          waits;
        logic        rdy1, rdy2, rdy3;
        logic        wbv1, wbv2, wbv3;
        logic        ill2, ill3;
        logic [2:0]  wba;
        logic [31:0] wbd;
    } obs_t;

    always #5 clk_i = ~clk_i;

    alu_issue_ctrl #(.DATA_WIDTH(32), .INSTR_WIDTH(16), .NUM_REGS(8)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .instr_ready_o(instr_ready_o), .func_o(func_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .imm_o(imm_o), .result_i(result_i), .wb_valid_o(wb_valid_o),
        .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .illegal_o(illegal_o),
        .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
    );

    // Behavioural ALU sitting on the other side of the block.
    always_comb begin
        result_i = 32'hDEAD_BEEF;
        case (func_o)
            FuncAdd:  result_i = rs1_data_o + rs2_data_o;
            FuncAddi: result_i = rs1_data_o + {{26{imm_o[5]}}, imm_o};
            FuncSub:  result_i = rs1_data_o - rs2_data_o;
            default:  result_i = 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int lo6);
        return 16'(((op & 15) << 12) | ((rd & 7) << 9) | ((rs1 & 7) << 6) | (lo6 & 63));
    endfunction

    // Architectural model: predicts the write-back and updates the model register file.
    task automatic model_exec(input logic [15:0] ins, output bit is_wb, output int rd,
                              output logic [31:0] val);
        int op, rs1, rs2, imm, simm;
        op  = int'(ins) / 4096;
        rd  = (int'(ins) / 512) % 8;
        rs1 = (int'(ins) / 64) % 8;
        rs2 = (int'(ins) / 8) % 8;
        imm = int'(ins) % 64;
        is_wb = 1'b1;
        val = '0;
        case (op)
            0: val = mregs[rs1] + mregs[rs2];
            1: begin
                simm = (imm >= 32) ? imm - 64 : imm;
                val = mregs[rs1] + 32'(simm);
            end
            2: val = mregs[rs1] - mregs[rs2];
            default: begin
                is_wb = 1'b0;
                rd = 0;
            end
        endcase
        if (is_wb && rd != 0) mregs[rd] = val;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) mregs[i] = '0;
    endtask

    task automatic peek(input int a, output logic [31:0] d);
        dbg_addr_i = 3'(a);
        #1;
        d = dbg_data_o;
    endtask

    // Presents one instruction, waits for acceptance (edge N) and samples cycles N+1..N+3.
    // Entered and left at 1 time unit after a rising edge.
    task automatic run_instr(input logic [15:0] ins, input bit hold_next,
                             input logic [15:0] nxt, output obs_t o);
        bit acc;
        o = '{default: '0};
        instr_i = ins;
        instr_valid_i = 1'b1;
        acc = 1'b0;
        while (!acc && o.waits < 50) begin
            acc = instr_ready_o;
            @(posedge clk_i); #1;
            if (!acc) o.waits++;
        end
        if (!acc) begin
            o.timeout = 1'b1;
            instr_valid_i = 1'b0;
            return;
        end
        o.rdy1 = instr_ready_o;
        o.wbv1 = wb_valid_o;
        if (hold_next) begin
            instr_i = nxt;
        end else begin
            instr_valid_i = 1'b0;
            instr_i = 16'($urandom);
        end
        @(posedge clk_i); #1;
        o.rdy2 = instr_ready_o;
        o.wbv2 = wb_valid_o;
        o.ill2 = illegal_o;
        o.wba  = wb_addr_o;
        o.wbd  = wb_data_o;
        @(posedge clk_i); #1;
        o.rdy3 = instr_ready_o;
        o.wbv3 = wb_valid_o;
        o.ill3 = illegal_o;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        clear_model();
        #1 arst_ni = 1'b0;
        #2;
        n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", instr_ready_o); end
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid_o); end
        n_checks++; if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got=%b exp=0", illegal_o); end
        n_checks++; if (func_o !== FuncInvalid) begin n_fail++; $display("FAIL rst_func got=%0d exp=%0d", func_o, FuncInvalid); end
        n_checks++; if ({rs1_data_o, rs2_data_o, imm_o} !== '0) begin n_fail++; $display("FAIL rst_operands got=%h/%h/%h exp=0", rs1_data_o, rs2_data_o, imm_o); end
        n_checks++; if (wb_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_wb_data got=%h exp=0", wb_data_o); end
        @(posedge clk_i); #1;
        arst_ni = 1'b1;
        peek(3, d);
        n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready got=%b exp=0", instr_ready_o); end
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_dbg_r3 got=%h exp=0", d); end
        @(posedge clk_i); #1;
        n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_first_cycle_ready got=%b exp=1", instr_ready_o); end
    endtask

    task automatic test_addi();
        obs_t o;
        bit ewb; int erd; logic [31:0] ev, d;
        run_instr(enc(1, 1, 0, 5), 1'b0, 16'h0, o);
        model_exec(enc(1, 1, 0, 5), ewb, erd, ev);
        n_checks++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL addi_accept got=timeout exp=accepted"); end
        n_checks++; if ({o.rdy1, o.wbv1} !== 2'b00) begin n_fail++; $display("FAIL addi_exec_cycle got rdy/wbv=%b%b exp=00", o.rdy1, o.wbv1); end
        n_checks++; if (o.wbv2 !== 1'b1) begin n_fail++; $display("FAIL addi_wb_valid got=%b exp=1", o.wbv2); end
        n_checks++; if (o.wba !== 3'd1) begin n_fail++; $display("FAIL addi_wb_addr got=%0d exp=1", o.wba); end
        n_checks++; if (o.wbd !== 32'h0000_0005) begin n_fail++; $display("FAIL addi_wb_data got=%h exp=00000005", o.wbd); end
        n_checks++; if ({o.wbv3, o.rdy3} !== 2'b01) begin n_fail++; $display("FAIL addi_after_wb got wbv/rdy=%b%b exp=01", o.wbv3, o.rdy3); end
        peek(1, d);
        n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL addi_dbg_r1 got=%h exp=00000005", d); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        bit ewb; int erd; logic [31:0] ev, d;
        logic [15:0] i1, i2;
        i1 = enc(1, 2, 0, 6'h3F);
        i2 = enc(0, 3, 1, 2 << 3);
        run_instr(i1, 1'b1, i2, o1);
        model_exec(i1, ewb, erd, ev);
        run_instr(i2, 1'b0, 16'h0, o2);
        model_exec(i2, ewb, erd, ev);
        n_checks++; if ({o1.rdy1, o1.rdy2} !== 2'b00) begin n_fail++; $display("FAIL b2b_held_not_ready got=%b%b exp=00", o1.rdy1, o1.rdy2); end
        n_checks++; if (o1.wbd !== 32'hFFFF_FFFF || o1.wba !== 3'd2) begin n_fail++; $display("FAIL b2b_r2 got=r%0d=%h exp=r2=ffffffff", o1.wba, o1.wbd); end
        n_checks++; if (o2.timeout !== 1'b0 || o2.waits !== 0) begin n_fail++; $display("FAIL b2b_accept_after_wb got waits=%0d to=%b exp=0/0", o2.waits, o2.timeout); end
        n_checks++; if (o2.wbv2 !== 1'b1 || o2.wba !== 3'd3) begin n_fail++; $display("FAIL b2b_r3_wb got v=%b r%0d exp v=1 r3", o2.wbv2, o2.wba); end
        n_checks++; if (o2.wbd !== 32'h0000_0004) begin n_fail++; $display("FAIL b2b_r3_data got=%h exp=00000004", o2.wbd); end
        peek(3, d);
        n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL b2b_dbg_r3 got=%h exp=00000004", d); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_sub_wrap();
        obs_t o;
        bit ewb; int erd; logic [31:0] ev, d;
        run_instr(enc(2, 4, 0, 1 << 3), 1'b0, 16'h0, o);
        model_exec(enc(2, 4, 0, 1 << 3), ewb, erd, ev);
        n_checks++; if (o.wbd !== 32'hFFFF_FFFB || o.wba !== 3'd4) begin n_fail++; $display("FAIL sub_r4 got=r%0d=%h exp=r4=fffffffb", o.wba, o.wbd); end
        run_instr(enc(0, 5, 4, 1 << 3), 1'b0, 16'h0, o);
        model_exec(enc(0, 5, 4, 1 << 3), ewb, erd, ev);
        n_checks++; if (o.wbd !== 32'h0 || o.wbv2 !== 1'b1 || o.ill2 !== 1'b0) begin n_fail++; $display("FAIL add_wrap_r5 got v=%b ill=%b d=%h exp v=1 ill=0 d=0", o.wbv2, o.ill2, o.wbd); end
        peek(4, d);
        n_checks++; if (d !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL sub_dbg_r4 got=%h exp=fffffffb", d); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_r0_illegal();
        obs_t o;
        bit ewb; int erd; logic [31:0] ev, d;
        logic [15:0] bad;
        run_instr(enc(1, 0, 0, 7), 1'b0, 16'h0, o);
        model_exec(enc(1, 0, 0, 7), ewb, erd, ev);
        n_checks++; if (o.wbv2 !== 1'b1 || o.wba !== 3'd0 || o.wbd !== 32'h7) begin n_fail++; $display("FAIL r0_wb got v=%b r%0d=%h exp v=1 r0=7", o.wbv2, o.wba, o.wbd); end
        peek(0, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL r0_dbg got=%h exp=0", d); end
        @(posedge clk_i); #1;
        bad = enc(15, 3, 2, int'($urandom_range(0, 63)));
        run_instr(bad, 1'b0, 16'h0, o);
        model_exec(bad, ewb, erd, ev);
        n_checks++; if ({o.ill2, o.wbv2} !== 2'b10) begin n_fail++; $display("FAIL illegal_pulse got ill/wbv=%b%b exp=10", o.ill2, o.wbv2); end
        n_checks++; if (o.ill3 !== 1'b0) begin n_fail++; $display("FAIL illegal_one_cycle got=%b exp=0", o.ill3); end
        for (int r = 0; r < 8; r++) begin
            peek(r, d);
            n_checks++; if (d !== mregs[r]) begin n_fail++; $display("FAIL illegal_regs_r%0d got=%h exp=%h", r, d, mregs[r]); end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid_exec();
        logic [31:0] d;
        instr_i = enc(1, 6, 0, 9);
        instr_valid_i = 1'b1;
        @(posedge clk_i); #1;
        instr_valid_i = 1'b0;
        n_checks++; if (func_o !== FuncAddi) begin n_fail++; $display("FAIL midrst_in_exec got func=%0d exp=%0d", func_o, FuncAddi); end
        arst_ni = 1'b0;
        clear_model();
        #1;
        n_checks++; if ({instr_ready_o, wb_valid_o, illegal_o} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got=%b%b%b exp=000", instr_ready_o, wb_valid_o, illegal_o); end
        n_checks++; if (func_o !== FuncInvalid || imm_o !== 6'h0 || rs1_data_o !== 32'h0) begin n_fail++; $display("FAIL midrst_outputs got func=%0d imm=%h rs1=%h exp=%0d/0/0", func_o, imm_o, rs1_data_o, FuncInvalid); end
        @(posedge clk_i); #1;
        n_checks++; if ({wb_valid_o, instr_ready_o} !== 2'b00) begin n_fail++; $display("FAIL midrst_held got wbv/rdy=%b%b exp=00", wb_valid_o, instr_ready_o); end
        arst_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if ({instr_ready_o, wb_valid_o} !== 2'b10) begin n_fail++; $display("FAIL midrst_release got rdy/wbv=%b%b exp=10", instr_ready_o, wb_valid_o); end
        peek(6, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_r6 got=%h exp=0", d); end
        peek(4, d);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_r4_cleared got=%h exp=0", d); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_random();
        obs_t o;
        bit ewb; int erd; logic [31:0] ev, d;
        logic [15:0] ins;
        int kind, op, n_ill_exp, n_ill_seen;
        n_ill_exp = 0;
        n_ill_seen = 0;
        for (int k = 0; k < 1000; k++) begin
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                instr_i = 16'($urandom);
                @(posedge clk_i); #1;
            end
            kind = int'($urandom_range(0, 3));
            op = (kind < 3) ? kind : int'($urandom_range(3, 15));
            ins = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 63)));
            model_exec(ins, ewb, erd, ev);
            if (!ewb) n_ill_exp++;
            run_instr(ins, 1'b0, 16'h0, o);
            if (o.ill2 === 1'b1) n_ill_seen++;
            n_checks++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL rnd_accept #%0d got=timeout exp=accepted", k); end
            n_checks++; if ({o.wbv2, o.ill2} !== {ewb, !ewb}) begin n_fail++; $display("FAIL rnd_kind #%0d ins=%h got wbv/ill=%b%b exp=%b%b", k, ins, o.wbv2, o.ill2, ewb, !ewb); end
            if (ewb) begin
                n_checks++; if (o.wba !== 3'(erd) || o.wbd !== ev) begin n_fail++; $display("FAIL rnd_wb #%0d ins=%h got r%0d=%h exp r%0d=%h", k, ins, o.wba, o.wbd, erd, ev); end
            end
        end
        for (int r = 0; r < 8; r++) begin
            peek(r, d);
            n_checks++; if (d !== mregs[r]) begin n_fail++; $display("FAIL rnd_regfile_r%0d got=%h exp=%h", r, d, mregs[r]); end
        end
        n_checks++; if (n_ill_seen !== n_ill_exp) begin n_fail++; $display("FAIL rnd_illegal_count got=%0d exp=%0d", n_ill_seen, n_ill_exp); end
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_sub_wrap();
        test_r0_illegal();
        test_reset_mid_exec();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
